umi_regif_arb: RTL and testbench
================================

# umi_regif_arb

Round-robin arbiter that lets N UMI requesters share one UMI register-interface device port (e.g. a `umi_regif` instance). It forwards one request at a time to the device and tracks which requester is owed a response. It returns each device response to that requester in order. Posted writes are forwarded with no response tracking.

## Interface
Parameters:
- N, 4, number of requester ports (2..16)
- AW, 64, address width
- CW, 32, command width
- DW, 256, data width
- DEPTH, 4, outstanding-response tracking FIFO depth (power of 2, >=2)

Ports:
- Clocking and reset (already decided): reset nreset, asynchronous, active-low; clock clk.
- clk  in  1  clock
- nreset  in  1  async active-low reset
- host_req_valid  in  N  per-port request valid
- host_req_cmd  in  N*CW  per-port command, port i at [i*CW+:CW]
- host_req_dstaddr  in  N*AW  per-port destination address
- host_req_srcaddr  in  N*AW  per-port source address
- host_req_data  in  N*DW  per-port data
- host_req_ready  out  N  per-port request ready
- host_resp_valid  out  N  per-port response valid (at most one bit set)
- host_resp_cmd  out  CW  shared response command
- host_resp_dstaddr  out  AW  shared response destination address
- host_resp_srcaddr  out  AW  shared response source address
- host_resp_data  out  DW  shared response data
- host_resp_ready  in  N  per-port response ready
- dev_req_valid, dev_req_cmd, dev_req_dstaddr, dev_req_srcaddr, dev_req_data  out  1/CW/AW/AW/DW  request to device
- dev_req_ready  in  1  device request ready
- dev_resp_valid, dev_resp_cmd, dev_resp_dstaddr, dev_resp_srcaddr, dev_resp_data  in  1/CW/AW/AW/DW  device response
- dev_resp_ready  out  1  device response ready
- resp_orphan  out  1  sticky: device response arrived with no tracked owner
- outstanding  out  $clog2(DEPTH)+1  tracked responses pending

## Operation
- Response expectation: decode the cmd[4:0] opcode.
  - READ (5'h01), WRITE (5'h03) and ATOMIC (5'h09) need a response.
  - POSTED (5'h05) and all other opcodes need none.
- Eligibility: port i is eligible when host_req_valid[i] is set and either (a) its request needs no response or (b) the FIFO is not full.
- Grant (no lock active):
  - Pick the first eligible port at or above rr_ptr, wrapping modulo N.
  - Combinational, one-hot.
- Lock: when dev_req_valid is set and dev_req_ready is clear, set a lock register and hold the grant index. The granted request must stay on the device port unchanged until accepted.
- Device request fields are a mux of the granted port. dev_req_valid = any grant.
- host_req_ready[i] = grant[i] & dev_req_ready.
- On accept (dev_req_valid & dev_req_ready):
  - Clear the lock.
  - Set rr_ptr = (granted index + 1) mod N.
  - If the request needs a response, push the granted index into the FIFO.
- Response routing:
  - The FIFO head selects the owner port.
  - host_resp_valid[head] = dev_resp_valid.
  - dev_resp_ready = host_resp_ready[head].
  - Shared response fields pass through from the device.
  - Pop the FIFO on dev_resp_valid & dev_resp_ready.
- FIFO empty with dev_resp_valid set:
  - Drive dev_resp_ready = 1 so the response is consumed.
  - Keep all host_resp_valid at 0.
  - Set resp_orphan; it stays set until reset.
- Push and pop in the same cycle: outstanding is unchanged, and head and tail both advance.
- Push on full cannot occur, because the eligibility rule prevents it. While a grant is locked, outstanding can only decrease, so eligibility cannot be lost.

## Timing
- Request path: zero cycles, combinational from host to device.
- Response path: zero cycles, combinational.
- State updates on the rising edge of clk.
- Reset values:
  - rr_ptr = 0, lock = 0.
  - FIFO empty, outstanding = 0, resp_orphan = 0.
  - host_resp_valid = 0, since the FIFO is empty and only orphan handling applies.
  - host_req_ready = 0 unless dev_req_ready is high.
- Reset asserted mid-transaction: all state is cleared immediately and pending response tracking is discarded. The device must be reset together with this block.
- Throughput: one device handshake per cycle; rate is limited by the device, e.g. umi_regif accepts one request per 2 cycles.

## Test plan
- Ports 0 and 2 both issue READs continuously, device always ready, responses echoed 2 cycles later -> accepts alternate 0,2,0,2; each response goes only to its issuer; outstanding never exceeds 2.
- Port 1 POSTED write while the FIFO is full (4 READs outstanding, responses held off) -> posted write is accepted and READs from other ports stall; releasing one response lets exactly one READ through.
- Port 3 request with dev_req_ready low for 5 cycles while port 0 asserts valid -> dev_req fields from port 3 are stable all 5 cycles; port 3 is accepted first, then port 0.
- Responses to ports 1 then 2, with host_resp_ready[1] held low for 3 cycles -> the port 2 response waits; delivery order is 1 then 2; dev_resp_ready tracks host_resp_ready[1].
- dev_resp_valid pulse with outstanding = 0 -> dev_resp_ready = 1, no host_resp_valid, resp_orphan sets and stays 1.
- nreset asserted with 3 responses outstanding -> outstanding = 0, rr_ptr = 0, all host_resp_valid = 0 the same cycle.

Source files
------------

// File: rtl/umi_regif_arb.sv
// Round-robin arbiter sharing one UMI register-interface device port among N requesters.
// A small owner FIFO routes device responses back to their issuers in order.

module umi_regif_arb_lane (
   input  logic       req_valid,
   input  logic [4:0] opcode,
   input  logic       fifo_full,
   input  logic       gnt,
   input  logic       dev_req_ready,
   input  logic       resp_sel,
   input  logic       dev_resp_valid,
   output logic       needs_resp,
   output logic       elig,
   output logic       req_ready,
   output logic       resp_valid
);
   // READ, WRITE and ATOMIC expect a response; POSTED and anything else do not
   assign needs_resp = (opcode == 5'h01) | (opcode == 5'h03) | (opcode == 5'h09);
   assign elig       = req_valid & (~needs_resp | ~fifo_full);
   assign req_ready  = gnt & dev_req_ready;
   assign resp_valid = resp_sel & dev_resp_valid;
endmodule

module umi_regif_arb #(
   parameter int N     = 4,
   parameter int AW    = 64,
   parameter int CW    = 32,
   parameter int DW    = 256,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     nreset,
   input  logic [N-1:0]             host_req_valid,
   input  logic [N*CW-1:0]          host_req_cmd,
   input  logic [N*AW-1:0]          host_req_dstaddr,
   input  logic [N*AW-1:0]          host_req_srcaddr,
   input  logic [N*DW-1:0]          host_req_data,
   output logic [N-1:0]             host_req_ready,
   output logic [N-1:0]             host_resp_valid,
   output logic [CW-1:0]            host_resp_cmd,
   output logic [AW-1:0]            host_resp_dstaddr,
   output logic [AW-1:0]            host_resp_srcaddr,
   output logic [DW-1:0]            host_resp_data,
   input  logic [N-1:0]             host_resp_ready,
   output logic                     dev_req_valid,
   output logic [CW-1:0]            dev_req_cmd,
   output logic [AW-1:0]            dev_req_dstaddr,
   output logic [AW-1:0]            dev_req_srcaddr,
   output logic [DW-1:0]            dev_req_data,
   input  logic                     dev_req_ready,
   input  logic                     dev_resp_valid,
   input  logic [CW-1:0]            dev_resp_cmd,
   input  logic [AW-1:0]            dev_resp_dstaddr,
   input  logic [AW-1:0]            dev_resp_srcaddr,
   input  logic [DW-1:0]            dev_resp_data,
   output logic                     dev_resp_ready,
   output logic                     resp_orphan,
   output logic [$clog2(DEPTH):0]   outstanding
);
   localparam int PW = $clog2(N);
   localparam int FW = $clog2(DEPTH);

   logic [N-1:0]              needs_resp, elig, gnt, resp_sel;
   logic                      gnt_any;
   logic [PW-1:0]             gnt_idx, next_ptr, rr_ptr, lock_idx, head;
   logic                      lock;
   logic [DEPTH-1:0][PW-1:0]  fifo_mem;
   logic [FW-1:0]             wr_ptr, rd_ptr;
   logic                      fifo_full, fifo_empty, accept, push, pop;
   int                        cand;

   assign fifo_full  = (outstanding == (FW+1)'(DEPTH));
   assign fifo_empty = (outstanding == '0);
   assign head       = fifo_mem[rd_ptr];

   for (genvar i = 0; i < N; i++) begin : g_lane
      assign gnt[i]      = gnt_any & (gnt_idx == PW'(i));
      assign resp_sel[i] = ~fifo_empty & (head == PW'(i));
      umi_regif_arb_lane u_lane (
         .req_valid      (host_req_valid[i]),
         .opcode         (host_req_cmd[i*CW +: 5]),
         .fifo_full      (fifo_full),
         .gnt            (gnt[i]),
         .dev_req_ready  (dev_req_ready),
         .resp_sel       (resp_sel[i]),
         .dev_resp_valid (dev_resp_valid),
         .needs_resp     (needs_resp[i]),
         .elig           (elig[i]),
         .req_ready      (host_req_ready[i]),
         .resp_valid     (host_resp_valid[i])
      );
   end

   // A stalled grant is pinned so the device sees a stable request until it accepts
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      cand    = 0;
      if (lock) begin
         gnt_any = 1'b1;
         gnt_idx = lock_idx;
      end else begin
         for (int k = 0; k < N; k++) begin
            cand = (int'(rr_ptr) + k) % N;
            if (!gnt_any && elig[cand]) begin
               gnt_any = 1'b1;
               gnt_idx = PW'(cand);
            end
         end
      end
   end

   assign next_ptr        = (gnt_idx == PW'(N-1)) ? '0 : gnt_idx + 1'b1;
   assign dev_req_valid   = gnt_any;
   assign dev_req_cmd     = host_req_cmd[int'(gnt_idx)*CW +: CW];
   assign dev_req_dstaddr = host_req_dstaddr[int'(gnt_idx)*AW +: AW];
   assign dev_req_srcaddr = host_req_srcaddr[int'(gnt_idx)*AW +: AW];
   assign dev_req_data    = host_req_data[int'(gnt_idx)*DW +: DW];

   assign accept = dev_req_valid & dev_req_ready;
   assign push   = accept & needs_resp[gnt_idx];
   // Ownerless responses are swallowed so the device never wedges
   assign dev_resp_ready = fifo_empty ? 1'b1 : host_resp_ready[head];
   assign pop    = dev_resp_valid & dev_resp_ready & ~fifo_empty;

   assign host_resp_cmd     = dev_resp_cmd;
   assign host_resp_dstaddr = dev_resp_dstaddr;
   assign host_resp_srcaddr = dev_resp_srcaddr;
   assign host_resp_data    = dev_resp_data;

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         rr_ptr      <= '0;
         lock        <= 1'b0;
         lock_idx    <= '0;
         fifo_mem    <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         outstanding <= '0;
         resp_orphan <= 1'b0;
      end else begin
         if (accept) begin
            lock   <= 1'b0;
            rr_ptr <= next_ptr;
         end else if (dev_req_valid) begin
            lock     <= 1'b1;
            lock_idx <= gnt_idx;
         end
         if (push) begin
            fifo_mem[wr_ptr] <= gnt_idx;
            wr_ptr           <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         if (push & ~pop)      outstanding <= outstanding + 1'b1;
         else if (pop & ~push) outstanding <= outstanding - 1'b1;
         if (dev_resp_valid & fifo_empty) resp_orphan <= 1'b1;
      end
   end
endmodule

// File: tb/tb_umi_regif_arb.sv
// Directed bench for umi_regif_arb: requester/device models with an owner scoreboard.

module tb_umi_regif_arb;
   localparam int N = 4, AW = 64, CW = 32, DW = 64, DEPTH = 4;
   localparam logic [4:0] RD = 5'h01, WR = 5'h03, PW = 5'h05, UNK = 5'h11;

   logic                   clk = 1'b0;
   logic                   nreset;
   logic [N-1:0]           host_req_valid, host_req_ready, host_resp_valid, host_resp_ready;
   logic [N*CW-1:0]        host_req_cmd;
   logic [N*AW-1:0]        host_req_dstaddr, host_req_srcaddr;
   logic [N*DW-1:0]        host_req_data;
   logic [CW-1:0]          host_resp_cmd, dev_req_cmd, dev_resp_cmd;
   logic [AW-1:0]          host_resp_dstaddr, host_resp_srcaddr, dev_req_dstaddr, dev_req_srcaddr;
   logic [AW-1:0]          dev_resp_dstaddr, dev_resp_srcaddr;
   logic [DW-1:0]          host_resp_data, dev_req_data, dev_resp_data;
   logic                   dev_req_valid, dev_req_ready, dev_resp_valid, dev_resp_ready;
   logic                   resp_orphan;
   logic [$clog2(DEPTH):0] outstanding;

   always #5 clk = ~clk;

   umi_regif_arb #(.N(N), .AW(AW), .CW(CW), .DW(DW), .DEPTH(DEPTH)) dut (
      .clk(clk), .nreset(nreset),
      .host_req_valid(host_req_valid), .host_req_cmd(host_req_cmd),
      .host_req_dstaddr(host_req_dstaddr), .host_req_srcaddr(host_req_srcaddr),
      .host_req_data(host_req_data), .host_req_ready(host_req_ready),
      .host_resp_valid(host_resp_valid), .host_resp_cmd(host_resp_cmd),
      .host_resp_dstaddr(host_resp_dstaddr), .host_resp_srcaddr(host_resp_srcaddr),
      .host_resp_data(host_resp_data), .host_resp_ready(host_resp_ready),
      .dev_req_valid(dev_req_valid), .dev_req_cmd(dev_req_cmd),
      .dev_req_dstaddr(dev_req_dstaddr), .dev_req_srcaddr(dev_req_srcaddr),
      .dev_req_data(dev_req_data), .dev_req_ready(dev_req_ready),
      .dev_resp_valid(dev_resp_valid), .dev_resp_cmd(dev_resp_cmd),
      .dev_resp_dstaddr(dev_resp_dstaddr), .dev_resp_srcaddr(dev_resp_srcaddr),
      .dev_resp_data(dev_resp_data), .dev_resp_ready(dev_resp_ready),
      .resp_orphan(resp_orphan), .outstanding(outstanding)
   );

   int nchk = 0, nerr = 0, cycle = 0, credits = 0, max_out = 0;
   int rem [N];
   int seq [N];
   logic [4:0] op [N];
   bit orph = 1'b0;
   logic [DW-1:0] dq_data [$];
   logic [CW-1:0] dq_cmd [$];
   logic [AW-1:0] dq_dst [$];
   logic [AW-1:0] dq_src [$];
   int dq_ts [$];
   int exp_port [$];
   logic [DW-1:0] exp_data [$];
   int acc_log [$];

   function automatic logic [CW-1:0] mk_cmd(int p, int s, logic [4:0] o);
      return {8'(p), 8'(s), 11'd0, o};
   endfunction
   function automatic logic [AW-1:0] mk_dst(int p, int s);
      return {24'hD00000, 8'(p), 24'h0, 8'(s)};
   endfunction
   function automatic logic [AW-1:0] mk_src(int p, int s);
      return {24'h5C0000, 8'(s), 24'h0, 8'(p)};
   endfunction
   function automatic logic [DW-1:0] mk_data(int p, int s);
      return {16'hDA7A, 8'(p), 8'(s), 16'h0, 8'(p), 8'(s)};
   endfunction
   function automatic bit needs(logic [4:0] o);
      return (o == 5'h01) || (o == 5'h03) || (o == 5'h09);
   endfunction

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
      nchk++;
      assert (obs === expv) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic drive();
      for (int p = 0; p < N; p++) begin
         host_req_valid[p]             = rem[p] > 0;
         host_req_cmd[p*CW +: CW]      = mk_cmd(p, seq[p], op[p]);
         host_req_dstaddr[p*AW +: AW]  = mk_dst(p, seq[p]);
         host_req_srcaddr[p*AW +: AW]  = mk_src(p, seq[p]);
         host_req_data[p*DW +: DW]     = mk_data(p, seq[p]);
      end
      dev_resp_valid = 1'b0;
      dev_resp_cmd = '0; dev_resp_dstaddr = '0; dev_resp_srcaddr = '0; dev_resp_data = '0;
      if (orph) begin
         dev_resp_valid = 1'b1;
         dev_resp_data  = 64'hDEAD;
      end else if (dq_ts.size() > 0 && credits > 0 && dq_ts[0] <= cycle) begin
         dev_resp_valid   = 1'b1;
         dev_resp_cmd     = dq_cmd[0];
         dev_resp_dstaddr = dq_src[0];
         dev_resp_srcaddr = dq_dst[0];
         dev_resp_data    = dq_data[0];
      end
   endtask

   task automatic sample();
      int p, hp;
      @(negedge clk);
      chk("outstanding_vs_model", 64'(outstanding), 64'(exp_port.size()));
      chk("resp_valid_onehot0", 64'($onehot0(host_resp_valid)), 1);
      if (int'(outstanding) > max_out) max_out = int'(outstanding);
      if (dev_req_valid && dev_req_ready) begin
         p = -1;
         for (int i = 0; i < N; i++) if (host_req_ready[i]) p = i;
         chk("req_ready_onehot", 64'($countones(host_req_ready)), 1);
         if (p >= 0) begin
            chk("acc_port_had_req", 64'(rem[p] > 0), 1);
            chk("dev_req_cmd", dev_req_cmd, mk_cmd(p, seq[p], op[p]));
            chk("dev_req_data", dev_req_data, mk_data(p, seq[p]));
            acc_log.push_back(p);
            if (needs(op[p])) begin
               dq_data.push_back(mk_data(p, seq[p])); dq_cmd.push_back(mk_cmd(p, seq[p], op[p]));
               dq_dst.push_back(mk_dst(p, seq[p]));   dq_src.push_back(mk_src(p, seq[p]));
               dq_ts.push_back(cycle + 2);
               exp_port.push_back(p); exp_data.push_back(mk_data(p, seq[p]));
            end
            if (rem[p] > 0) rem[p]--;
            seq[p]++;
         end
      end
      if (dev_resp_valid && dev_resp_ready) begin
         hp = -1;
         for (int i = 0; i < N; i++) if (host_resp_valid[i]) hp = i;
         if (orph) begin
            chk("orphan_no_host_valid", 64'(host_resp_valid), 0);
            orph = 1'b0;
         end else begin
            chk("resp_owner_found", 64'(hp >= 0 && exp_port.size() > 0), 1);
            if (hp >= 0 && exp_port.size() > 0) begin
               chk("resp_port", 64'(hp), 64'(exp_port[0]));
               chk("resp_data", host_resp_data, exp_data[0]);
               chk("resp_srcaddr", host_resp_srcaddr, dq_dst[0]);
               void'(exp_port.pop_front()); void'(exp_data.pop_front());
            end
            if (dq_ts.size() > 0) begin
               void'(dq_ts.pop_front()); void'(dq_data.pop_front()); void'(dq_cmd.pop_front());
               void'(dq_dst.pop_front()); void'(dq_src.pop_front());
               credits--;
            end
         end
      end
   endtask

   task automatic fin();
      @(posedge clk); #1;
      cycle++;
   endtask

   task automatic cyc();
      drive(); sample(); fin();
   endtask

   function automatic bit idle(bit need_dq);
      for (int p = 0; p < N; p++) if (rem[p] != 0) return 1'b0;
      return !need_dq || dq_ts.size() == 0;
   endfunction

   task automatic wait_drain(string tag, bit need_dq, int budget);
      int n = 0;
      while (n < budget && !idle(need_dq)) begin cyc(); n++; end
      chk({tag, "_drained"}, 64'(idle(need_dq)), 1);
   endtask

   initial begin
      nreset = 1'b0; dev_req_ready = 1'b0; host_resp_ready = '1;
      for (int p = 0; p < N; p++) begin rem[p] = 0; seq[p] = 0; op[p] = RD; end
      drive();
      #1;
      chk("rst_outstanding", 64'(outstanding), 0);
      chk("rst_orphan", 64'(resp_orphan), 0);
      chk("rst_resp_valid", 64'(host_resp_valid), 0);
      chk("rst_req_ready", 64'(host_req_ready), 0);
      chk("rst_dev_req_valid", 64'(dev_req_valid), 0);
      @(posedge clk); #1; nreset = 1'b1;

      // two READ streams alternate under round robin
      dev_req_ready = 1'b1; credits = 1000; max_out = 0; acc_log.delete();
      rem[0] = 3; rem[2] = 3;
      wait_drain("t1", 1, 60);
      chk("t1_acc_count", 64'(acc_log.size()), 6);
      for (int i = 0; i < acc_log.size() && i < 6; i++) chk("t1_acc_order", 64'(acc_log[i]), 64'((i % 2) * 2));
      chk("t1_max_outstanding", 64'(max_out), 2);

      // full FIFO: posted passes, reads stall until one response frees a slot
      credits = 0; rem[0] = 4;
      wait_drain("t2_fill", 0, 30);
      chk("t2_full", 64'(outstanding), 4);
      acc_log.delete(); rem[0] = 1; rem[2] = 1; rem[1] = 1; op[1] = PW;
      repeat (4) cyc();
      chk("t2_acc_count", 64'(acc_log.size()), 1);
      if (acc_log.size() > 0) chk("t2_posted_port", 64'(acc_log[0]), 1);
      chk("t2_port2_stalled", 64'(rem[2]), 1);
      credits = 1;
      repeat (4) cyc();
      chk("t2_one_through", 64'(acc_log.size()), 2);
      if (acc_log.size() > 1) chk("t2_second_port", 64'(acc_log[1]), 2);
      chk("t2_port0_stalled", 64'(rem[0]), 1);
      chk("t2_full_again", 64'(outstanding), 4);
      credits = 1000;
      wait_drain("t2", 1, 60);

      // an unknown opcode from port 3 is untracked and parks rr_ptr at 0
      op[3] = UNK; rem[3] = 1;
      wait_drain("t3_prep", 1, 20);
      chk("t3_unk_untracked", 64'(outstanding), 0);

      // stalled port 3 grant stays pinned while port 0 competes
      dev_req_ready = 1'b0; acc_log.delete(); op[3] = RD; rem[3] = 1;
      cyc();
      rem[0] = 1;
      for (int i = 0; i < 5; i++) begin
         drive(); sample();
         chk("t3_valid", 64'(dev_req_valid), 1);
         chk("t3_data", dev_req_data, mk_data(3, seq[3]));
         chk("t3_dst", dev_req_dstaddr, mk_dst(3, seq[3]));
         chk("t3_cmd", dev_req_cmd, mk_cmd(3, seq[3], RD));
         fin();
      end
      dev_req_ready = 1'b1;
      wait_drain("t3", 1, 30);
      chk("t3_acc_count", 64'(acc_log.size()), 2);
      if (acc_log.size() > 1) begin
         chk("t3_first", 64'(acc_log[0]), 3);
         chk("t3_second", 64'(acc_log[1]), 0);
      end

      // response to port 1 back-pressured; port 2 response must wait behind it
      credits = 0; acc_log.delete(); op[1] = RD; op[2] = WR; rem[1] = 1; rem[2] = 1;
      wait_drain("t4_issue", 0, 20);
      if (acc_log.size() > 1) chk("t4_issue_order", 64'(acc_log[0] * 10 + acc_log[1]), 12);
      host_resp_ready[1] = 1'b0; credits = 1000;
      for (int i = 0; i < 3; i++) begin
         drive(); sample();
         chk("t4_valid_port1", 64'(host_resp_valid), 64'(4'b0010));
         chk("t4_dev_ready_low", 64'(dev_resp_ready), 0);
         fin();
      end
      host_resp_ready[1] = 1'b1;
      drive(); sample();
      chk("t4_dev_ready_high", 64'(dev_resp_ready), 1);
      fin();
      wait_drain("t4", 1, 20);

      // response with nothing outstanding is consumed and flagged
      chk("t5_orphan_clear", 64'(resp_orphan), 0);
      orph = 1'b1;
      drive(); sample();
      chk("t5_dev_ready", 64'(dev_resp_ready), 1);
      chk("t5_no_host_valid", 64'(host_resp_valid), 0);
      fin();
      orph = 1'b0;
      repeat (3) cyc();
      chk("t5_orphan_sticky", 64'(resp_orphan), 1);

      // async reset with three responses pending
      credits = 0; op[0] = RD; rem[0] = 3;
      wait_drain("t6_issue", 0, 20);
      chk("t6_pre_outstanding", 64'(outstanding), 3);
      credits = 1000; rem[0] = 1; rem[1] = 1; op[1] = RD;
      drive();
      @(negedge clk);
      chk("t6_pre_resp_valid", 64'(host_resp_valid), 64'(4'b0001));
      nreset = 1'b0;
      exp_port.delete(); exp_data.delete(); dq_ts.delete(); dq_data.delete();
      dq_cmd.delete(); dq_dst.delete(); dq_src.delete();
      #1;
      chk("t6_outstanding", 64'(outstanding), 0);
      chk("t6_resp_valid", 64'(host_resp_valid), 0);
      chk("t6_orphan", 64'(resp_orphan), 0);
      chk("t6_rr_ptr_zero", 64'(host_req_ready), 64'(4'b0001));
      fin();
      nreset = 1'b1;
      wait_drain("t6", 1, 30);
      chk("end_outstanding", 64'(outstanding), 0);

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1);
   end
endmodule
